// File: rtl/adder_chk_pkg.sv
// Shared types and helpers for the adder sweep checker.
// The expected-sum helper is sized for the widest supported operand; callers truncate.
package adder_chk_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int ERRW     = 16;
    localparam int EXP_MAXW = 16;

    function automatic logic [EXP_MAXW:0] exp_sum(input logic [EXP_MAXW-1:0] a,
                                                  input logic [EXP_MAXW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO holding expected results for in-flight operations.
// Flush empties it in one cycle and wins over a simultaneous push or pop.
module sync_fifo #(
    parameter  int W     = 9,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/adder_sweep_checker.sv
// Sweeps all (A,B) operand pairs into an adder DUT and checks the returned {carry,sum}
// against expected values queued at issue time; reports sticky pass/fail status.
module adder_sweep_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int A_MAX       = 25,
    parameter int B_MAX       = 10,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 64,
    parameter int STOP_ON_ERR = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             op_valid_o,
    input  logic             res_valid_i,
    input  logic             carry_i,
    input  logic [WIDTH-1:0] sum_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    output logic [ERRW-1:0]  err_count_o,
    output logic [WIDTH-1:0] err_a_o,
    output logic [WIDTH-1:0] err_b_o,
    output logic [WIDTH:0]   err_got_o
);
    localparam int RW = WIDTH + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t            state_q, state_d;
    logic [RW-1:0]     a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  chk_a_q, chk_a_d, chk_b_q, chk_b_d;
    logic [15:0]       wd_q, wd_d;
    logic [AW+1:0]     discard_q, discard_d;
    logic [ERRW-1:0]   err_count_q, err_count_d;
    logic [WIDTH-1:0]  err_a_q, err_a_d, err_b_q, err_b_d;
    logic [RW-1:0]     err_got_q, err_got_d;
    logic              timeout_q, timeout_d, pass_q, pass_d;

    logic              busy, issue, pop, flush, mis, start_go, last_issue, wd_fire, abort;
    logic              fifo_full, fifo_empty;
    logic [RW-1:0]     fifo_din, fifo_dout, got;
    logic [AW:0]       fifo_level;

    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign issue      = (state_q == RUN) && !fifo_full;
    assign got        = {carry_i, sum_i};
    assign pop        = res_valid_i && busy && !fifo_empty;
    // Outside a sweep, results still owed by an aborted sweep are silently absorbed.
    assign mis        = res_valid_i && (busy ? (fifo_empty || got != fifo_dout)
                                             : (discard_q == '0));
    assign start_go   = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign last_issue = issue && (a_q == RW'(A_MAX)) && (b_q == RW'(B_MAX));
    assign wd_fire    = busy && !fifo_empty && !res_valid_i && (wd_q == 16'd1);
    assign abort      = busy && (wd_fire || (mis && STOP_ON_ERR != 0));
    assign flush      = abort || start_go;
    assign fifo_din   = RW'(exp_sum(EXP_MAXW'(a_q[WIDTH-1:0]), EXP_MAXW'(b_q[WIDTH-1:0])));

    sync_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (issue),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        chk_a_d     = chk_a_q;
        chk_b_d     = chk_b_q;
        wd_d        = wd_q;
        discard_d   = discard_q;
        err_count_d = err_count_q;
        err_a_d     = err_a_q;
        err_b_d     = err_b_q;
        err_got_d   = err_got_q;
        timeout_d   = timeout_q;
        pass_d      = pass_q;

        case (state_q)
            IDLE:    if (start_go)   state_d = RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    if (start_go)   state_d = RUN;
            default:                 state_d = IDLE;
        endcase
        if (abort) state_d = DONE;

        if (issue) begin
            if (b_q == RW'(B_MAX)) begin
                b_d = '0;
                a_d = a_q + RW'(1);
            end else begin
                b_d = b_q + RW'(1);
            end
        end

        // Check-side counters replay the issue order so a mismatch can name its operands.
        if (pop) begin
            if (chk_b_q == WIDTH'(B_MAX)) begin
                chk_b_d = '0;
                chk_a_d = chk_a_q + WIDTH'(1);
            end else begin
                chk_b_d = chk_b_q + WIDTH'(1);
            end
        end

        if (!busy || fifo_empty || res_valid_i) wd_d = 16'(TIMEOUT);
        else if (wd_q != 16'd1)                 wd_d = wd_q - 16'd1;
        if (wd_fire) timeout_d = 1'b1;

        if (abort)
            discard_d = (AW+2)'(fifo_level) + (AW+2)'(issue) - (AW+2)'(pop);
        else if (!busy && res_valid_i && discard_q != '0)
            discard_d = discard_q - (AW+2)'(1);

        if (mis) begin
            if (err_count_q == '0) begin
                err_got_d = got;
                err_a_d   = (busy && !fifo_empty) ? chk_a_q : '0;
                err_b_d   = (busy && !fifo_empty) ? chk_b_q : '0;
            end
            if (err_count_q != '1) err_count_d = err_count_q + ERRW'(1);
        end

        if (state_d == DONE && state_q != DONE)
            pass_d = (err_count_d == '0) && !timeout_d;

        if (start_go) begin
            a_d         = '0;
            b_d         = '0;
            chk_a_d     = '0;
            chk_b_d     = '0;
            wd_d        = 16'(TIMEOUT);
            discard_d   = '0;
            err_count_d = '0;
            err_a_d     = '0;
            err_b_d     = '0;
            err_got_d   = '0;
            timeout_d   = 1'b0;
            pass_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            chk_a_q     <= '0;
            chk_b_q     <= '0;
            wd_q        <= 16'(TIMEOUT);
            discard_q   <= '0;
            err_count_q <= '0;
            err_a_q     <= '0;
            err_b_q     <= '0;
            err_got_q   <= '0;
            timeout_q   <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            chk_a_q     <= chk_a_d;
            chk_b_q     <= chk_b_d;
            wd_q        <= wd_d;
            discard_q   <= discard_d;
            err_count_q <= err_count_d;
            err_a_q     <= err_a_d;
            err_b_q     <= err_b_d;
            err_got_q   <= err_got_d;
            timeout_q   <= timeout_d;
            pass_q      <= pass_d;
        end
    end

    assign a_o         = a_q[WIDTH-1:0];
    assign b_o         = b_q[WIDTH-1:0];
    assign op_valid_o  = issue;
    assign busy_o      = busy;
    assign done_o      = (state_q == DONE);
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign err_count_o = err_count_q;
    assign err_a_o     = err_a_q;
    assign err_b_o     = err_b_q;
    assign err_got_o   = err_got_q;
endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker: three instances (default, count-all, full 8-bit sweep)
// each driven by a behavioural adder with programmable latency, stalls and faults.
module tb_adder_sweep_checker;
    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [NI];
    logic [7:0] a [NI], b [NI], sum [NI], erra [NI], errb [NI];
    logic       opv [NI], resv [NI], carry [NI], busy [NI], done [NI], pass [NI], tout [NI];
    logic [15:0] errc [NI];
    logic [8:0]  errg [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_inst
        adder_sweep_checker #(
            .WIDTH(8), .A_MAX(k == 2 ? 255 : 25), .B_MAX(k == 2 ? 255 : 10),
            .FIFO_DEPTH(4), .TIMEOUT(64), .STOP_ON_ERR(k == 1 ? 0 : 1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start_i(start[k]),
            .a_o(a[k]), .b_o(b[k]), .op_valid_o(opv[k]),
            .res_valid_i(resv[k]), .carry_i(carry[k]), .sum_i(sum[k]),
            .busy_o(busy[k]), .done_o(done[k]), .pass_o(pass[k]), .timeout_o(tout[k]),
            .err_count_o(errc[k]), .err_a_o(erra[k]), .err_b_o(errb[k]), .err_got_o(errg[k])
        );
    end

    typedef struct { bit v; int a; int b; } op_t;
    typedef struct { int a; int b; } pair_t;

    op_t   pipe [NI][$];
    op_t   outq [NI][$];
    pair_t exp_q [NI][$];
    int    lat [NI], mode [NI], clr_req [NI], clr_seen [NI];
    bit    stall [NI], tie0 [NI];
    int    issued [NI], returned [NI], max_ahead [NI];
    int    checks = 0, errors = 0, cyc = 0;

    // Adder under test: mode 3 inverts carry at (20,10); mode 4 returns sum+1 whenever b==0.
    function automatic logic [8:0] dut_res(int md, int x, int y);
        logic [8:0] r;
        r = 9'(x + y);
        if (md == 3 && x == 20 && y == 10) r[8] = ~r[8];
        if (md == 4 && y == 0) r = r + 9'd1;
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Behavioural DUT: captures each cycle's operation, returns it lat cycles later.
    always @(posedge clk) begin
        op_t o, e;
        logic [8:0] r;
        #1;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n || clr_req[k] != clr_seen[k]) begin
                pipe[k].delete();
                outq[k].delete();
                clr_seen[k] = clr_req[k];
            end
            resv[k]  = 1'b0;
            carry[k] = 1'b0;
            sum[k]   = 8'd0;
            if (rst_n) begin
                o.v = opv[k]; o.a = int'(a[k]); o.b = int'(b[k]);
                pipe[k].push_back(o);
                while (pipe[k].size() > lat[k]) begin
                    e = pipe[k].pop_front();
                    if (e.v) outq[k].push_back(e);
                end
                if (!stall[k] && !tie0[k] && outq[k].size() > 0) begin
                    e = outq[k].pop_front();
                    r = dut_res(mode[k], e.a, e.b);
                    resv[k]  = 1'b1;
                    carry[k] = r[8];
                    sum[k]   = r[7:0];
                end
            end
        end
    end

    // Monitor: every issued operation must be the next pair of the reference sweep.
    always @(negedge clk) begin
        pair_t p;
        for (int k = 0; k < NI; k++) begin
            if (rst_n) begin
                if (opv[k]) begin
                    issued[k]++;
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL op_order[%0d] unexpected issue a=%0d b=%0d", k, a[k], b[k]);
                    end else begin
                        p = exp_q[k].pop_front();
                        if (p.a != int'(a[k]) || p.b != int'(b[k])) begin
                            errors++;
                            $display("FAIL op_order[%0d] got a=%0d b=%0d expected a=%0d b=%0d",
                                     k, a[k], b[k], p.a, p.b);
                        end
                    end
                end
                if (resv[k]) returned[k]++;
                if (issued[k] - returned[k] > max_ahead[k]) max_ahead[k] = issued[k] - returned[k];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", nm, got, want);
        end
    endtask

    task automatic chk_zero(input int k);
        chk($sformatf("reset_outputs[%0d]", k),
            64'({a[k], b[k], opv[k], busy[k], done[k], pass[k], tout[k],
                 errc[k], erra[k], errb[k], errg[k]}), 64'd0);
    endtask

    // Reference: nested sweep order plus the error picture the faulty adder should cause.
    task automatic load_ref(input int k, input int amax, input int bmax, input int md,
                            input bit stop, output int n_ops, output int n_mis,
                            output int fa, output int fb, output logic [8:0] fg);
        logic [8:0] r;
        pair_t p;
        exp_q[k].delete();
        n_ops = 0; n_mis = 0; fa = 0; fb = 0; fg = '0;
        for (int x = 0; x <= amax; x++) begin
            for (int y = 0; y <= bmax; y++) begin
                p.a = x; p.b = y;
                exp_q[k].push_back(p);
                n_ops++;
                r = dut_res(md, x, y);
                if (r != 9'(x + y)) begin
                    if (n_mis == 0) begin fa = x; fb = y; fg = r; end
                    n_mis++;
                end
            end
        end
        if (stop && n_mis > 0) n_mis = 1;
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk); start[k] = 1'b1;
        @(negedge clk); start[k] = 1'b0;
    endtask

    task automatic run_sweep(input int k, input int budget, output int dcyc);
        int n, c0;
        issued[k] = 0; returned[k] = 0; max_ahead[k] = 0;
        pulse_start(k);
        chk($sformatf("first_op_after_start[%0d]", k), 64'(opv[k]), 64'd1);
        c0 = cyc;
        n = 0;
        while (!done[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("done_within_budget[%0d]", k), 64'(done[k]), 64'd1);
        dcyc = cyc - c0;
    endtask

    initial begin
        int n_ops, n_mis, fa, fb, d;
        logic [8:0] fg;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0; lat[k] = 1; mode[k] = 0; stall[k] = 1'b0; tie0[k] = 1'b0;
            clr_req[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) chk_zero(k);
        rst_n = 1'b1;

        // T1: ideal adder, latency 1
        load_ref(0, 25, 10, 0, 1'b1, n_ops, n_mis, fa, fb, fg);
        run_sweep(0, 2000, d);
        chk("t1_issues", 64'(issued[0]), 64'(n_ops));
        chk("t1_pass", 64'(pass[0]), 64'd1);
        chk("t1_err_count", 64'(errc[0]), 64'd0);
        chk("t1_timeout", 64'(tout[0]), 64'd0);

        // T2: latency 3, random 5-cycle stall, stray start while busy
        lat[0] = 3;
        load_ref(0, 25, 10, 0, 1'b1, n_ops, n_mis, fa, fb, fg);
        fork
            run_sweep(0, 2000, d);
            begin
                repeat ($urandom_range(30, 150)) @(negedge clk);
                stall[0] = 1'b1;
                repeat (5) @(negedge clk);
                stall[0] = 1'b0;
            end
            begin
                repeat ($urandom_range(20, 100)) @(negedge clk);
                start[0] = 1'b1;
                @(negedge clk);
                start[0] = 1'b0;
            end
        join
        chk("t2_issues", 64'(issued[0]), 64'(n_ops));
        chk("t2_max_ahead_le4", 64'(max_ahead[0] <= 4), 64'd1);
        chk("t2_pass", 64'(pass[0]), 64'd1);
        chk("t2_err_count", 64'(errc[0]), 64'd0);

        // T3: carry corrupted at (20,10), stop on first error
        lat[0] = 1; mode[0] = 3;
        load_ref(0, 25, 10, 3, 1'b1, n_ops, n_mis, fa, fb, fg);
        run_sweep(0, 2000, d);
        chk("t3_pass", 64'(pass[0]), 64'd0);
        chk("t3_err_a", 64'(erra[0]), 64'(fa));
        chk("t3_err_b", 64'(errb[0]), 64'(fb));
        chk("t3_err_got", 64'(errg[0]), 64'(fg));
        chk("t3_err_count", 64'(errc[0]), 64'(n_mis));
        repeat (8) @(negedge clk);
        chk("t3_late_results_discarded", 64'(errc[0]), 64'(n_mis));
        exp_q[0].delete();
        mode[0] = 0;

        // T4: count-all instance, sum+1 whenever b==0
        mode[1] = 4;
        load_ref(1, 25, 10, 4, 1'b0, n_ops, n_mis, fa, fb, fg);
        run_sweep(1, 2000, d);
        chk("t4_issues", 64'(issued[1]), 64'(n_ops));
        chk("t4_err_count", 64'(errc[1]), 64'(n_mis));
        chk("t4_err_a", 64'(erra[1]), 64'(fa));
        chk("t4_err_b", 64'(errb[1]), 64'(fb));
        chk("t4_err_got", 64'(errg[1]), 64'(fg));
        chk("t4_pass", 64'(pass[1]), 64'd0);

        // T5: full 8-bit sweep, ends at 255+255
        load_ref(2, 255, 255, 0, 1'b1, n_ops, n_mis, fa, fb, fg);
        run_sweep(2, 70000, d);
        chk("t5_issues", 64'(issued[2]), 64'(n_ops));
        chk("t5_pass", 64'(pass[2]), 64'd1);
        chk("t5_err_count", 64'(errc[2]), 64'd0);

        // T6: results never return; watchdog counts 64 stalled cycles after the issue cycle
        tie0[0] = 1'b1;
        load_ref(0, 25, 10, 0, 1'b1, n_ops, n_mis, fa, fb, fg);
        run_sweep(0, 300, d);
        chk("t6_timeout", 64'(tout[0]), 64'd1);
        chk("t6_pass", 64'(pass[0]), 64'd0);
        chk("t6_done_delay", 64'(d), 64'(64 + 1));
        tie0[0] = 1'b0;
        clr_req[0]++;
        load_ref(0, 25, 10, 0, 1'b1, n_ops, n_mis, fa, fb, fg);
        pulse_start(0);
        repeat (10) @(negedge clk);
        chk("t6_busy_before_reset", 64'(busy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) chk_zero(k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
